// File: rtl/qedmma_pkg.sv
// -----------------------------------------------------------------------------
// qedmma_pkg
//   Shared fixed-point definitions for the Kalman covariance path.
//   fp_t is a signed two's-complement Q(DATA_WIDTH-FRAC_BITS).FRAC_BITS value.
//   FP_MAX / FP_MIN are the saturation bounds used by every arithmetic stage.
// -----------------------------------------------------------------------------
package qedmma_pkg;

  localparam int STATE_DIM  = 4;
  localparam int DATA_WIDTH = 32;
  localparam int FRAC_BITS  = 16;

  typedef logic signed [DATA_WIDTH-1:0] fp_t;

  // Row / column index into a STATE_DIM x STATE_DIM matrix.
  typedef logic [$clog2(STATE_DIM)-1:0] idx_t;

  localparam fp_t FP_MAX = {1'b0, {(DATA_WIDTH-1){1'b1}}};
  localparam fp_t FP_MIN = {1'b1, {(DATA_WIDTH-1){1'b0}}};

endpackage : qedmma_pkg

// File: rtl/fp_sym_add_sat.sv
// -----------------------------------------------------------------------------
// fp_sym_add_sat
//   Combinational per-element conditioning unit:
//     result = sat( floor((c_ij + c_ji) / 2) + q )
//   The sum is formed one bit wider than fp_t, halved with an arithmetic shift
//   (rounds toward -inf), then q is added two bits wider than fp_t so the
//   overflow test is exact before clamping to [FP_MIN, FP_MAX].
//
// Ports
//   c_ij, c_ji : in  fp_t   mirrored pair of the product matrix
//   q          : in  fp_t   process-noise term for this element
//   result     : out fp_t   saturated result
//   sat        : out logic  result was clamped
// -----------------------------------------------------------------------------
module fp_sym_add_sat
  import qedmma_pkg::*;
(
  input  fp_t  c_ij,
  input  fp_t  c_ji,
  input  fp_t  q,
  output fp_t  result,
  output logic sat
);

  logic signed [DATA_WIDTH:0]   s;
  logic signed [DATA_WIDTH:0]   h;
  logic signed [DATA_WIDTH+1:0] t;

  // NOTE: combinational temporaries use blocking '=' so each line sees the
  // value computed by the line above within the same evaluation.
  always_comb begin
    s = $signed({c_ij[DATA_WIDTH-1], c_ij}) + $signed({c_ji[DATA_WIDTH-1], c_ji});
    h = s >>> 1;
    t = $signed({h[DATA_WIDTH], h}) + $signed({{2{q[DATA_WIDTH-1]}}, q});

    // t fits in fp_t exactly when its top three bits agree.
    sat    = !((t[DATA_WIDTH+1] == t[DATA_WIDTH]) && (t[DATA_WIDTH] == t[DATA_WIDTH-1]));
    result = t[DATA_WIDTH-1:0];
    if (sat) begin
      result = t[DATA_WIDTH+1] ? FP_MIN : FP_MAX;
    end
  end

endmodule : fp_sym_add_sat

// File: rtl/covariance_finalize_4x4.sv
// -----------------------------------------------------------------------------
// covariance_finalize_4x4
//   Conditions the F*P*F' product into a covariance estimate:
//     P_out = sat( (C + C')/2 + Q )        (Q upper triangle mirrored)
//   One row per cycle: accept -> ROW0..ROW3 -> OUT (held until out_ready).
//   P_out[i][j] and P_out[j][i] come from identical operands, so the result is
//   bit-exactly symmetric.
//
// Build option
//   QEDMMA_DIAG_FLOOR_EN : when defined, diagonal results below DIAG_MIN are
//                          replaced by DIAG_MIN and floor_flag is raised.
//                          When undefined, floor_flag is tied 0.
//
// Parameters
//   DIAG_MIN   : diagonal floor value (only used with QEDMMA_DIAG_FLOOR_EN)
//
// Ports
//   clk, rst_n : clock, asynchronous active-low reset
//   in_valid   : in   C and Q valid (a single-cycle pulse is enough)
//   in_ready   : out  high only while idle
//   C          : in   4x4 product matrix
//   Q          : in   4x4 process noise, upper triangle (i<=j) used
//   P_out      : out  conditioned covariance, registered
//   out_valid  : out  P_out valid, held until out_ready
//   out_ready  : in   downstream accept
//   sat_flag   : out  some element of this P_out saturated
//   floor_flag : out  some diagonal element of this P_out was floored
// -----------------------------------------------------------------------------
module covariance_finalize_4x4
  import qedmma_pkg::*;
#(
  parameter fp_t DIAG_MIN = fp_t'(1)
) (
  input  logic clk,
  input  logic rst_n,
  input  logic in_valid,
  output logic in_ready,
  input  fp_t  C     [STATE_DIM][STATE_DIM],
  input  fp_t  Q     [STATE_DIM][STATE_DIM],
  output fp_t  P_out [STATE_DIM][STATE_DIM],
  output logic out_valid,
  input  logic out_ready,
  output logic sat_flag,
  output logic floor_flag
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ROW0,
    S_ROW1,
    S_ROW2,
    S_ROW3,
    S_OUT
  } state_t;

  state_t state;
  state_t state_next;

  logic accept;
  logic row_en;
  idx_t row;

  fp_t  c_reg [STATE_DIM][STATE_DIM];
  fp_t  q_reg [STATE_DIM][STATE_DIM];

  idx_t q_lo  [STATE_DIM];
  idx_t q_hi  [STATE_DIM];
  fp_t  q_sel [STATE_DIM];
  fp_t  sum   [STATE_DIM];
  fp_t  elem  [STATE_DIM];
  logic [STATE_DIM-1:0] sat_vec;

  // ---------------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // ---------------------------------------------------------------------------
  // FSM: next state
  // ---------------------------------------------------------------------------
  always_comb begin
    state_next = state;
    unique case (state)
      S_IDLE:  if (in_valid) state_next = S_ROW0;
      S_ROW0:  state_next = S_ROW1;
      S_ROW1:  state_next = S_ROW2;
      S_ROW2:  state_next = S_ROW3;
      S_ROW3:  state_next = S_OUT;
      S_OUT:   if (out_ready) state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // FSM: outputs decoded from state
  // ---------------------------------------------------------------------------
  // NOTE: every output gets a default before the case so no path leaves a
  // value unassigned, which would otherwise infer a latch.
  always_comb begin
    in_ready  = 1'b0;
    out_valid = 1'b0;
    row_en    = 1'b0;
    row       = '0;
    unique case (state)
      S_IDLE: in_ready = 1'b1;
      S_ROW0: begin row_en = 1'b1; row = idx_t'(0); end
      S_ROW1: begin row_en = 1'b1; row = idx_t'(1); end
      S_ROW2: begin row_en = 1'b1; row = idx_t'(2); end
      S_ROW3: begin row_en = 1'b1; row = idx_t'(3); end
      S_OUT:  out_valid = 1'b1;
      default: ;
    endcase
  end

  assign accept = in_valid && in_ready;

  // ---------------------------------------------------------------------------
  // Operand capture
  // ---------------------------------------------------------------------------
  // NOTE: the operand stores are pure data, overwritten on every accept and
  // never read before that, so they carry no reset.
  always_ff @(posedge clk) begin
    if (accept) begin
      c_reg <= C;
      q_reg <= Q;
    end
  end

  // ---------------------------------------------------------------------------
  // Row datapath: four element units share the current row index. Q is read
  // from its upper triangle regardless of which side of the diagonal the
  // element sits on.
  // ---------------------------------------------------------------------------
  always_comb begin
    for (int j = 0; j < STATE_DIM; j++) begin
      if (idx_t'(j) < row) begin
        q_lo[j] = idx_t'(j);
        q_hi[j] = row;
      end else begin
        q_lo[j] = row;
        q_hi[j] = idx_t'(j);
      end
      q_sel[j] = q_reg[q_lo[j]][q_hi[j]];
    end
  end

  for (genvar j = 0; j < STATE_DIM; j++) begin : g_col
    fp_sym_add_sat u_elem (
      .c_ij   (c_reg[row][j]),
      .c_ji   (c_reg[j][row]),
      .q      (q_sel[j]),
      .result (sum[j]),
      .sat    (sat_vec[j])
    );
  end

`ifdef QEDMMA_DIAG_FLOOR_EN
  logic [STATE_DIM-1:0] floor_vec;

  // Only the column that lands on the diagonal of the current row is floored.
  always_comb begin
    for (int j = 0; j < STATE_DIM; j++) begin
      elem[j]      = sum[j];
      floor_vec[j] = 1'b0;
      if ((idx_t'(j) == row) && (sum[j] < DIAG_MIN)) begin
        elem[j]      = DIAG_MIN;
        floor_vec[j] = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      floor_flag <= 1'b0;
    end else if (accept) begin
      floor_flag <= 1'b0;
    end else if (row_en && (|floor_vec)) begin
      floor_flag <= 1'b1;
    end
  end
`else
  fp_t diag_min_unused;

  assign diag_min_unused = DIAG_MIN;
  assign elem            = sum;
  assign floor_flag      = 1'b0;
`endif

  // ---------------------------------------------------------------------------
  // Result registers and sticky saturation flag
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < STATE_DIM; i++) begin
        for (int j = 0; j < STATE_DIM; j++) begin
          P_out[i][j] <= '0;
        end
      end
    end else if (row_en) begin
      for (int j = 0; j < STATE_DIM; j++) begin
        P_out[row][j] <= elem[j];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sat_flag <= 1'b0;
    end else if (accept) begin
      sat_flag <= 1'b0;
    end else if (row_en && (|sat_vec)) begin
      sat_flag <= 1'b1;
    end
  end

endmodule : covariance_finalize_4x4

// File: tb/tb_covariance_finalize_4x4.sv
// -----------------------------------------------------------------------------
// tb_covariance_finalize_4x4
//   Self-checking bench for covariance_finalize_4x4. Expected matrices come
//   from plain integer arithmetic on the input matrices (exact floor halving,
//   clamp, optional diagonal floor), independent of the RTL structure.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_covariance_finalize_4x4;
  import qedmma_pkg::*;

  localparam longint LIM_HI     = (longint'(1) <<< (DATA_WIDTH-1)) - 1;
  localparam longint LIM_LO     = -(longint'(1) <<< (DATA_WIDTH-1));
  localparam longint ONE        = longint'(1) <<< FRAC_BITS;
  localparam longint DIAG_MIN_V = 1;

  logic clk = 1'b0;
  logic rst_n;
  logic in_valid;
  logic in_ready;
  logic out_valid;
  logic out_ready;
  logic sat_flag;
  logic floor_flag;
  fp_t  c_in  [STATE_DIM][STATE_DIM];
  fp_t  q_in  [STATE_DIM][STATE_DIM];
  fp_t  p_out [STATE_DIM][STATE_DIM];

  longint exp_p [STATE_DIM][STATE_DIM];
  logic   exp_sat;
  logic   exp_floor;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  covariance_finalize_4x4 dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .C          (c_in),
    .Q          (q_in),
    .P_out      (p_out),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .sat_flag   (sat_flag),
    .floor_flag (floor_flag)
  );

  task automatic check(input string tag, input longint got, input longint exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic clear_inputs();
    for (int i = 0; i < STATE_DIM; i++) begin
      for (int j = 0; j < STATE_DIM; j++) begin
        c_in[i][j] = '0;
        q_in[i][j] = '0;
      end
    end
  endtask

  function automatic fp_t rand_val();
    case ($urandom_range(0, 2))
      0:       return fp_t'(int'($urandom_range(0, 2000)) - 1000);
      1:       return fp_t'($urandom);
      default: return ($urandom_range(0, 1) == 0) ? fp_t'(LIM_HI - longint'($urandom_range(0, 255)))
                                                   : fp_t'(LIM_LO + longint'($urandom_range(0, 255)));
    endcase
  endfunction

  // Reference: P = clamp(floor((C[i][j]+C[j][i])/2) + Q[min][max]).
  task automatic compute_expected();
    longint s, h, t, q;
    exp_sat   = 1'b0;
    exp_floor = 1'b0;
    for (int i = 0; i < STATE_DIM; i++) begin
      for (int j = 0; j < STATE_DIM; j++) begin
        s = longint'(c_in[i][j]) + longint'(c_in[j][i]);
        h = (s >= 0) ? (s / 2) : -((-s + 1) / 2);
        q = (i <= j) ? longint'(q_in[i][j]) : longint'(q_in[j][i]);
        t = h + q;
        if (t > LIM_HI) begin
          t = LIM_HI;
          exp_sat = 1'b1;
        end else if (t < LIM_LO) begin
          t = LIM_LO;
          exp_sat = 1'b1;
        end
`ifdef QEDMMA_DIAG_FLOOR_EN
        if (i == j && t < DIAG_MIN_V) begin
          t = DIAG_MIN_V;
          exp_floor = 1'b1;
        end
`endif
        exp_p[i][j] = t;
      end
    end
  endtask

  task automatic check_outputs(input string tag);
    for (int i = 0; i < STATE_DIM; i++) begin
      for (int j = 0; j < STATE_DIM; j++) begin
        check($sformatf("%s P[%0d][%0d]", tag, i, j), longint'(p_out[i][j]), exp_p[i][j]);
        if (j > i) begin
          check($sformatf("%s sym[%0d][%0d]", tag, i, j), longint'(p_out[j][i]), longint'(p_out[i][j]));
        end
      end
    end
    check({tag, " sat_flag"}, longint'(sat_flag), longint'(exp_sat));
    check({tag, " floor_flag"}, longint'(floor_flag), longint'(exp_floor));
  endtask

  // Present the current c_in/q_in, wait for out_valid (bounded), check the
  // latency and the result, then accept it with a one-cycle out_ready.
  task automatic run_matrix(input string tag);
    int n;
    n = 0;
    while (!in_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    check({tag, " in_ready before"}, longint'(in_ready), 1);
    compute_expected();
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    n = 1;
    while (!out_valid && n < 12) begin
      @(negedge clk);
      n++;
    end
    check({tag, " latency"}, longint'(n), 5);
    check_outputs(tag);
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check({tag, " out_valid drop"}, longint'(out_valid), 0);
    check({tag, " in_ready after"}, longint'(in_ready), 1);
  endtask

  initial begin
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    clear_inputs();

    // Reset state
    repeat (2) @(negedge clk);
    check("rst in_ready", longint'(in_ready), 1);
    check("rst out_valid", longint'(out_valid), 0);
    check("rst sat_flag", longint'(sat_flag), 0);
    check("rst floor_flag", longint'(floor_flag), 0);
    for (int i = 0; i < STATE_DIM; i++) begin
      for (int j = 0; j < STATE_DIM; j++) begin
        check($sformatf("rst P[%0d][%0d]", i, j), longint'(p_out[i][j]), 0);
      end
    end
    rst_n = 1'b1;
    @(negedge clk);

    // Symmetric identity plus small diagonal noise
    clear_inputs();
    for (int i = 0; i < STATE_DIM; i++) begin
      c_in[i][i] = fp_t'(ONE);
      q_in[i][i] = fp_t'((ONE * 1) / 100);
    end
    run_matrix("ident");
    check("ident diag value", longint'(p_out[3][3]), ONE + (ONE / 100));

    // Asymmetric pair, floor halving toward -inf
    clear_inputs();
    c_in[0][1] = fp_t'(3);
    run_matrix("asym+3");
    check("asym+3 P01", longint'(p_out[0][1]), 1);
    c_in[0][1] = fp_t'(-3);
    run_matrix("asym-3");
    check("asym-3 P10", longint'(p_out[1][0]), -2);

    // Saturation, then a clean matrix clears the flag
    clear_inputs();
    c_in[2][2] = FP_MAX;
    q_in[2][2] = fp_t'(ONE);
    run_matrix("sat");
    check("sat P22", longint'(p_out[2][2]), LIM_HI);
    check("sat flag set", longint'(sat_flag), 1);
    clear_inputs();
    c_in[1][2] = fp_t'(100);
    run_matrix("clean");
    check("clean flag clear", longint'(sat_flag), 0);

    // Negative diagonal: floored only when the feature is built
    clear_inputs();
    c_in[1][1] = fp_t'(-5);
    run_matrix("diag");
`ifdef QEDMMA_DIAG_FLOOR_EN
    check("diag floor P11", longint'(p_out[1][1]), DIAG_MIN_V);
    check("diag floor flag", longint'(floor_flag), 1);
`else
    check("diag nofloor P11", longint'(p_out[1][1]), -5);
    check("diag nofloor flag", longint'(floor_flag), 0);
`endif

    // Randomized matrices, including lower-triangle Q garbage that must be ignored
    for (int k = 0; k < 12; k++) begin
      for (int i = 0; i < STATE_DIM; i++) begin
        for (int j = 0; j < STATE_DIM; j++) begin
          c_in[i][j] = rand_val();
          q_in[i][j] = rand_val();
        end
      end
      run_matrix($sformatf("rand%0d", k));
    end

    // Backpressure: hold out_ready low, pulse in_valid with new data
    begin
      int n;
      for (int i = 0; i < STATE_DIM; i++) begin
        for (int j = 0; j < STATE_DIM; j++) begin
          c_in[i][j] = rand_val();
          q_in[i][j] = fp_t'(int'($urandom_range(0, 50)));
        end
      end
      compute_expected();
      in_valid = 1'b1;
      @(negedge clk);
      in_valid = 1'b0;
      n = 1;
      while (!out_valid && n < 12) begin
        @(negedge clk);
        n++;
      end
      check("bp latency", longint'(n), 5);
      for (int cyc = 0; cyc < 10; cyc++) begin
        in_valid   = 1'b1;
        c_in[0][0] = rand_val();
        c_in[3][2] = rand_val();
        @(negedge clk);
        check($sformatf("bp%0d out_valid", cyc), longint'(out_valid), 1);
        check($sformatf("bp%0d in_ready", cyc), longint'(in_ready), 0);
        check($sformatf("bp%0d P00", cyc), longint'(p_out[0][0]), exp_p[0][0]);
        check($sformatf("bp%0d P23", cyc), longint'(p_out[2][3]), exp_p[2][3]);
      end
      in_valid = 1'b0;
      check_outputs("bp hold");
      out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;
      check("bp release out_valid", longint'(out_valid), 0);
      check("bp release in_ready", longint'(in_ready), 1);
      for (int cyc = 0; cyc < 6; cyc++) begin
        @(negedge clk);
        check($sformatf("bp noqueue%0d", cyc), longint'(out_valid), 0);
      end
    end

    // Reset while in S_ROW2 with sat_flag already raised by row 0
    clear_inputs();
    c_in[0][0] = FP_MAX;
    q_in[0][0] = fp_t'(ONE);
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (2) @(negedge clk);
    check("mid pre-reset sat", longint'(sat_flag), 1);
    check("mid pre-reset P00", longint'(p_out[0][0]), LIM_HI);
    rst_n = 1'b0;
    #1;
    check("mid rst in_ready", longint'(in_ready), 1);
    check("mid rst out_valid", longint'(out_valid), 0);
    check("mid rst sat_flag", longint'(sat_flag), 0);
    check("mid rst floor_flag", longint'(floor_flag), 0);
    for (int i = 0; i < STATE_DIM; i++) begin
      for (int j = 0; j < STATE_DIM; j++) begin
        check($sformatf("mid rst P[%0d][%0d]", i, j), longint'(p_out[i][j]), 0);
      end
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("post rst in_ready", longint'(in_ready), 1);
    for (int i = 0; i < STATE_DIM; i++) begin
      for (int j = 0; j < STATE_DIM; j++) begin
        c_in[i][j] = fp_t'(int'($urandom_range(0, 4000)) - 2000);
        q_in[i][j] = fp_t'(int'($urandom_range(0, 100)));
      end
    end
    run_matrix("post rst");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Absolute time limit so the run always terminates.
  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule : tb_covariance_finalize_4x4
